ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  - Iterative RV32M multiply/divide engine in the EX stage.
//  - Consumes operands, funct3 and rd from the ID/EX register outputs.
//  - Drives stall_o back to PC, IF/ID and ID/EX so the issuing instruction is held until the result is ready.
//  - Result and rd go to the EX/MEM forwarding and result mux.
// PARAMETERS
//  - XLEN  32  operand/result width; equals `datawidth
// PORTS
//  - clk             in   1     rising-edge clock
//  - rst_n           in   1     asynchronous active-low reset
//  - valid_i         in   1     ID/EX holds an M-extension op (opcode OP, funct7=0000001)
//  - funct3_i        in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  - op_a_i          in   XLEN  rs1 value, post-forwarding
//  - op_b_i          in   XLEN  rs2 value, post-forwarding
//  - rd_i            in   5     destination register
//  - flush_i         in   1     branch flush; aborts any operation in flight
//  - stall_o         out  1     hold PC, IF/ID and ID/EX (combinational)
//  - busy_o          out  1     state != IDLE
//  - result_valid_o  out  1     one-cycle pulse; result_o/rd_o valid
//  - result_o        out  XLEN  product or quotient/remainder
//  - rd_o            out  5     rd of the completed op
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, result_o=0, rd_o=0, result_valid_o=0, busy_o=0.
//    stall_o is gated by rst_n and is 0 while in reset.
//  - Reset mid-operation discards the op; no result_valid_o pulse.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    - IDLE & valid_i & !flush_i: latch |a|, |b|, sign flags, funct3, rd. cnt<=0. Go to BUSY.
//    - BUSY: one iteration per cycle. Go to DONE after XLEN iterations (cnt==XLEN-1).
//    - DONE: result_o/rd_o registered, result_valid_o=1 for exactly 1 cycle. Go to IDLE unconditionally.
//      The op still visible on valid_i in DONE must not restart.
//  - stall_o = rst_n & valid_i & (state!=DONE) & !flush_i.
//    - Stall is high for XLEN+1 cycles: the accept cycle plus the BUSY cycles.
//    - Stall drops in the DONE cycle so ID/EX advances on that edge.
//  - Multiply: shift-add on a 2*XLEN accumulator, unsigned magnitudes.
//    - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//    - The 2*XLEN result is negated when the operand signs differ: MULH uses both signs, MULHSU uses a's sign only.
//  - Divide: restoring, 1 quotient bit per cycle, on magnitudes.
//    - Quotient sign = sa^sb.
//    - Remainder sign = sign of the dividend.
//  - Divide by zero (b==0): skip BUSY, go IDLE->DONE. Quotient=all ones; remainder=a. Stall is 1 cycle.
//  - Signed overflow (DIV/REM, a=0x80000000, b=-1): skip BUSY. Quotient=0x80000000, remainder=0.
//  - flush_i at any state: go to IDLE next edge. No result_valid_o. result_o/rd_o keep their old values.
//  - valid_i dropping while BUSY (ID/EX reset) is treated as an abort, same as flush.
// CONFIGURATION
//  - Macro FAST_MUL_EN.
//    - Defined: MUL* ops compute with a single-cycle 2*XLEN `*` and go IDLE->DONE, so stall_o is high for 1 cycle.
//      Divides are unchanged.
//    - Undefined: multiplies are iterative with XLEN+1 stall cycles, and no hardware multiplier is inferred.
// STRUCTURE
//  - muldiv_pkg holds:
//    - funct3 localparams: F3_MUL..F3_REMU.
//    - state encoding: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
//    - XLEN default.
//  - Sub-module muldiv_sign_fix: combinational abs() on inputs, plus a conditional 2*XLEN negate and select on output.
//    The iterate loop stays in ex_muldiv_unit.
// TESTING
//  - MUL: 7*-3 -> result_o=0xFFFFFFEB (-21), stall_o high 33 cycles, one result_valid_o pulse, rd_o=rd_i.
//  - MULH / MULHU / MULHSU with a=0x80000000, b=0xFFFFFFFF:
//    MULH -> 0x00000000, MULHU -> 0x7FFFFFFF, MULHSU -> 0x80000000.
//  - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
//    In all these cases stall_o is high exactly 1 cycle.
//  - flush_i at BUSY cycle 10 -> IDLE next edge, no result_valid_o.
//    A back-to-back new op is accepted normally afterwards.
//  - rst_n low at BUSY cycle 5 -> all outputs 0 immediately.
//    After release, a MUL 3*4 -> 12.
//  - With FAST_MUL_EN defined: MUL 3*4 -> 12 with stall_o high 1 cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide engine: funct3 codes,
// FSM state encoding, default data width and operand-signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic a_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterate loop: magnitudes and sign flags
// of the incoming operands, and a conditional 2*XLEN negate plus half select.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              sign_a,
  output logic              sign_b,
  input  logic [2*XLEN-1:0] raw,
  input  logic              negate,
  input  logic              hi_sel,
  output logic [XLEN-1:0]   fixed
);

  logic [2*XLEN-1:0] adj;

  always_comb begin
    sign_a = op_a[XLEN-1] & a_signed(funct3);
    sign_b = op_b[XLEN-1] & b_signed(funct3);
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    abs_a  = sign_a ? -op_a : op_a;
    abs_b  = sign_b ? -op_b : op_b;
    adj    = negate ? -raw : raw;
    fixed  = hi_sel ? adj[2*XLEN-1:XLEN] : adj[XLEN-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage; stalls the front end
// until the result is ready. Optional macro FAST_MUL_EN: single-cycle multiplies.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);

  state_e            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;

  logic [XLEN-1:0]   abs_a, abs_b, fixed;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] fix_raw;
  logic              fix_neg, fix_hi;

  logic [2:0]        f3_sel;
  logic              s_a, s_b, rem_sel;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_result;
  logic              load_result;
  logic [XLEN-1:0]   result_nxt;
`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;

  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_a   (op_a_i),
    .op_b   (op_b_i),
    .funct3 (funct3_i),
    .abs_a  (abs_a),
    .abs_b  (abs_b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .raw    (fix_raw),
    .negate (fix_neg),
    .hi_sel (fix_hi),
    .fixed  (fixed)
  );

  // One iteration step: shift-add multiply (multiplier in acc low half) or
  // restoring divide (remainder in acc high half, quotient shifting into low half).
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (f3_q[2]) begin
      acc_nxt = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Output sign fix sees live inputs while accepting, latched flags afterwards.
  always_comb begin
    f3_sel  = (state == ST_IDLE) ? funct3_i : f3_q;
    s_a     = (state == ST_IDLE) ? sign_a : sa_q;
    s_b     = (state == ST_IDLE) ? sign_b : sb_q;
    rem_sel = f3_sel[2] & f3_sel[1];
    fix_neg = rem_sel ? s_a : (s_a ^ s_b);
    fix_hi  = ~f3_sel[2] & (f3_sel != F3_MUL);
    if (f3_q[2]) begin
      fix_raw = (f3_q[1]) ? {{XLEN{1'b0}}, acc_nxt[2*XLEN-1:XLEN]}
                          : {{XLEN{1'b0}}, acc_nxt[XLEN-1:0]};
    end else begin
      fix_raw = acc_nxt;
    end
`ifdef FAST_MUL_EN
    if (state == ST_IDLE) fix_raw = fast_prod;
`endif
  end

  always_comb begin
    div_zero = funct3_i[2] & (op_b_i == {XLEN{1'b0}});
    div_ovf  = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == {XLEN{1'b1}});
    if (div_zero) spec_result = funct3_i[1] ? op_a_i : {XLEN{1'b1}};
    else          spec_result = funct3_i[1] ? {XLEN{1'b0}} : op_a_i;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    load_result = 1'b0;
    result_nxt  = fixed;
    case (state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (div_zero || div_ovf) begin
            load_result = 1'b1;
            result_nxt  = spec_result;
            state_nxt   = ST_DONE;
          end
`ifdef FAST_MUL_EN
          else if (!funct3_i[2]) begin
            load_result = 1'b1;
            state_nxt   = ST_DONE;
          end
`endif
          else begin
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush_i || !valid_i) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CW'(XLEN-1)) begin
          load_result = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) begin
      state_nxt   = ST_IDLE;
      load_result = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && valid_i && !flush_i) begin
        acc  <= funct3_i[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
        opnd <= funct3_i[2] ? abs_b : abs_a;
        f3_q <= funct3_i;
        rd_q <= rd_i;
        sa_q <= sign_a;
        sb_q <= sign_b;
        cnt  <= '0;
      end else if (state == ST_BUSY) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
      if (load_result) begin
        result_o <= result_nxt;
        rd_o     <= (state == ST_IDLE) ? rd_i : rd_q;
      end
    end
  end

  assign busy_o         = (state != ST_IDLE);
  assign result_valid_o = (state == ST_DONE);
  assign stall_o        = rst_n & valid_i & (state != ST_DONE) & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: results, stall lengths,
// special divides, flush abort and mid-operation reset.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .funct3_i       (funct3_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_o           (rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, hold it on valid_i until the result pulse, then retire it.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_stall);
    int stall_cnt = 0;
    int pulses    = 0;
    int cyc       = 0;
    logic [31:0] got_res = 'x;
    logic [4:0]  got_rd  = 'x;
    @(posedge clk); #1;
    valid_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd;
    while (cyc < 100 && pulses == 0) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (result_valid_o) begin
        pulses++;
        got_res = result_o;
        got_rd  = rd_o;
      end
      cyc++;
    end
    @(posedge clk); #1;
    check($sformatf("%s idle_after_done", name), {31'd0, busy_o}, 32'd0);
    valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
    check($sformatf("%s result", name), got_res, exp_res);
    check($sformatf("%s rd", name), {27'd0, got_rd}, {27'd0, rd});
    check($sformatf("%s stall_cycles", name), stall_cnt, exp_stall);
    check($sformatf("%s valid_pulses", name), pulses, 32'd1);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; valid_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'd3; op_b_i = 32'd4;
    rd_i = 5'd1; flush_i = 1'b0;
    #12;
    check("reset stall_gated", {31'd0, stall_o}, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset result_valid", {31'd0, result_valid_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", {27'd0, rd_o}, 32'd0);
    valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    run_op("MUL 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_STALL);
    run_op("MULH", F3_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, MUL_STALL);
    run_op("MULHU", F3_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h7FFF_FFFF, MUL_STALL);
    run_op("MULHSU", F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, MUL_STALL);
    run_op("DIV -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", F3_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 33);
    run_op("REMU 100/7", F3_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 33);
    run_op("DIV 5/0", F3_DIV, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op("REM 5/0", F3_REM, 32'd5, 32'd0, 5'd15, 32'd5, 1);
    run_op("REM ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
    run_op("DIV ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);

    // Flush at BUSY cycle 10: abort, no pulse, outputs keep the DIV ovf result.
    @(posedge clk); #1;
    valid_i = 1'b1; funct3_i = F3_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd20;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("flush busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush stall_dropped", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush idle_next_edge", {31'd0, busy_o}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
    check("flush no_pulse", pulses, 32'd0);
    check("flush result_kept", result_o, 32'h8000_0000);
    check("flush rd_kept", {27'd0, rd_o}, 32'd17);
    run_op("DIVU after flush", F3_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 33);

    // Reset at BUSY cycle 5: everything clears at once.
    @(posedge clk); #1;
    valid_i = 1'b1; funct3_i = F3_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd22;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset stall", {31'd0, stall_o}, 32'd0);
    check("midreset busy", {31'd0, busy_o}, 32'd0);
    check("midreset result_valid", {31'd0, result_valid_o}, 32'd0);
    check("midreset result", result_o, 32'd0);
    check("midreset rd", {27'd0, rd_o}, 32'd0);
    valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op("MUL 3*4 after reset", F3_MUL, 32'd3, 32'd4, 5'd3, 32'd12, MUL_STALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
